usart_rx_fifo: RTL and testbench

//  Receive-side buffer directly downstream of the USART receiver. Detects the receiver's
//  per-byte toggle strobe, captures the accompanying byte into a DEPTH-entry FIFO, and presents

---
 rtl/usart_rx_fifo_pkg.sv | 18 +
 rtl/usart_fifo_mem.sv | 29 ++
 rtl/usart_rx_fifo.sv | 97 +++++++++
 tb/tb_usart_rx_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usart_rx_fifo_pkg.sv
// usart_rx_fifo_pkg: shared widths and the ceil-log2 helper for the USART receive FIFO.
`default_nettype none

package usart_rx_fifo_pkg;

  localparam int USART_DATA_BIT   = 8;
  localparam int USART_FIFO_DEPTH = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usart_fifo_mem.sv
// usart_fifo_mem: DEPTH x DATA_BIT storage, synchronous write, asynchronous read.
`default_nettype none

module usart_fifo_mem
  import usart_rx_fifo_pkg::*;
#(
  parameter int DATA_BIT = USART_DATA_BIT,
  parameter int DEPTH    = USART_FIFO_DEPTH,
  parameter int ADDR_W   = clog2(USART_FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_BIT-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_BIT-1:0] rd_data_o
);

  logic [DATA_BIT-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo: toggle-strobe byte capture into a FWFT FIFO with sticky overflow.
`default_nettype none

module usart_rx_fifo
  import usart_rx_fifo_pkg::*;
#(
  parameter  int DATA_BIT = USART_DATA_BIT,
  parameter  int DEPTH    = USART_FIFO_DEPTH,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_BIT-1:0] rx_data,
  input  logic                rx_toggle,
  output logic [DATA_BIT-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                overflow,
  input  logic                clr_overflow
);

  logic                prev_toggle_q;
  logic                armed_q;
  logic                evt_q;
  logic [DATA_BIT-1:0] byte_q;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;

  logic                empty;
  logic                rd_evt;
  logic                wr_en;
  logic                ovf_set;
  logic [DATA_BIT-1:0] mem_rdata;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign rd_evt  = !empty && m_ready;
  // A read on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_en   = evt_q && (!full || rd_evt);
  assign ovf_set = evt_q && full && !rd_evt;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_evt) rd_ptr_d = rd_ptr_q + 1'b1;
    if (ovf_set)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // Edge detect is registered together with its byte; the write lands one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_toggle_q <= 1'b0;
      armed_q       <= 1'b0;
      evt_q         <= 1'b0;
      byte_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      prev_toggle_q <= rx_toggle;
      armed_q       <= 1'b1;
      evt_q         <= armed_q && (rx_toggle ^ prev_toggle_q);
      byte_q        <= rx_data;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
    end
  end

  usart_fifo_mem #(
    .DATA_BIT (DATA_BIT),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (byte_q),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (mem_rdata)
  );

  assign m_data   = empty ? '0 : mem_rdata;
  assign m_valid  = !empty;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_usart_rx_fifo.sv
// tb_usart_rx_fifo: table vectors, directed corner sequences and random traffic vs a queue model.
`default_nettype none

module tb_usart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_toggle = 1'b1;
  logic       m_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic [4:0] count;
  logic       full;
  logic       overflow;

  always #5 clk = ~clk;

  usart_rx_fifo dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_toggle    (rx_toggle),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: byte queue plus the one detected-but-not-yet-stored byte.
  logic [7:0] mq[$];
  bit         m_ovf, m_armed, m_prev, m_pend;
  logic [7:0] m_pend_data;
  bit         tog = 1'b1;

  typedef struct {
    bit       flip;
    bit [7:0] data;
    bit       rdy;
    bit       clr;
    int       exp_count;
    bit       exp_valid;
    bit [7:0] exp_data;
    bit       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_armed = 0; m_prev = 0; m_pend = 0; m_pend_data = 8'h00;
  endtask

  task automatic model_edge(input bit t, input logic [7:0] d, input bit rdy, input bit clr);
    bit rd;
    bit set;
    rd  = (mq.size() > 0) && rdy;
    set = 0;
    if (rd) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend_data);
      else set = 1;
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_pend      = m_armed && (t != m_prev);
    m_pend_data = d;
    m_prev      = t;
    m_armed     = 1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_valid"}, int'(m_valid), int'(mq.size() > 0));
    chk({tag, "_data"}, int'(m_data), (mq.size() > 0) ? int'(mq[0]) : 0);
    chk({tag, "_full"}, int'(full), int'(mq.size() == DEPTH));
    chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
  endtask

  // Called just after a falling edge: drive, clock once, check on the next falling edge.
  task automatic step(input bit flip, input logic [7:0] d, input bit rdy, input bit clr,
                      input string tag);
    if (flip) tog = ~tog;
    rx_toggle    = tog;
    rx_data      = d;
    m_ready      = rdy;
    clr_overflow = clr;
    @(posedge clk);
    model_edge(tog, d, rdy, clr);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset(input bit start_tog);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    tog = start_tog;
    rx_toggle = tog;
    reset_n = 1'b1;
    step(0, 8'h00, 0, 0, "arm");
  endtask

  initial begin
    logic [7:0] last;
    bit         saw_ee;

    vecs[0]  = '{1, 8'hA5, 0, 0, 0, 0, 8'h00, 0};
    vecs[1]  = '{0, 8'h00, 0, 0, 1, 1, 8'hA5, 0};
    vecs[2]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    vecs[3]  = '{1, 8'h3C, 0, 0, 0, 0, 8'h00, 0};
    vecs[4]  = '{1, 8'hC3, 0, 0, 1, 1, 8'h3C, 0};
    vecs[5]  = '{0, 8'h00, 1, 0, 1, 1, 8'hC3, 0};
    vecs[6]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    vecs[7]  = '{1, 8'h77, 1, 0, 0, 0, 8'h00, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 1, 1, 8'h77, 0};
    vecs[9]  = '{0, 8'h00, 0, 1, 1, 1, 8'h77, 0};
    vecs[10] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};

    // T1: release with toggle high; arming edge must not write.
    do_reset(1'b1);
    chk("t1_count", int'(count), 0);
    chk("t1_valid", int'(m_valid), 0);
    step(0, 8'h00, 0, 0, "t1_idle");
    chk("t1_idle_count", int'(count), 0);

    // T2 and short mixed traffic from the vector table.
    foreach (vecs[i]) begin
      step(vecs[i].flip, vecs[i].data, vecs[i].rdy, vecs[i].clr, "vec");
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d_valid", i), int'(m_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i), int'(m_data), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
    end

    // T3: fill, drain in order, then refill across the pointer wrap.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "t3_fill");
    step(0, 8'h00, 0, 0, "t3_settle");
    chk("t3_full", int'(full), 1);
    chk("t3_count16", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", int'(m_data), i);
      step(0, 8'h00, 1, 0, "t3_drain");
    end
    chk("t3_empty", int'(m_valid), 0);
    for (int i = 16; i < 24; i++) step(1, 8'(i), 0, 0, "t3_wfill");
    step(0, 8'h00, 0, 0, "t3_wsettle");
    for (int i = 16; i < 24; i++) begin
      chk("t3_wrap_order", int'(m_data), i);
      step(0, 8'h00, 1, 0, "t3_wdrain");
    end
    chk("t3_wrap_empty", int'(count), 0);

    // T4: overflow drop and clear.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, "t4_fill");
    step(0, 8'h00, 0, 0, "t4_settle");
    step(1, 8'hEE, 0, 0, "t4_ee");
    step(0, 8'h00, 0, 0, "t4_drop");
    chk("t4_count", int'(count), 16);
    chk("t4_ovf", int'(overflow), 1);
    step(0, 8'h00, 0, 1, "t4_clr");
    chk("t4_ovf_clr", int'(overflow), 0);

    // T5: write event meets a read while full.
    step(1, 8'h55, 0, 0, "t5_detect");
    step(0, 8'h00, 1, 0, "t5_rw");
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_count", int'(count), 16);
    saw_ee = 0;
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = m_data;
      if (m_data == 8'hEE) saw_ee = 1;
      step(0, 8'h00, 1, 0, "t5_drain");
    end
    chk("t5_last", int'(last), 8'h55);
    chk("t4_no_ee", int'(saw_ee), 0);

    // T6: asynchronous reset between edges.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, "t6_fill");
    step(0, 8'h00, 0, 0, "t6_settle");
    chk("t6_count5", int'(count), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_count", int'(count), 0);
    chk("t6_async_valid", int'(m_valid), 0);
    @(negedge clk);
    do_reset(1'b0);

    // Random traffic: low-ready phase pushes into full/overflow, high-ready phase drains.
    for (int i = 0; i < 500; i++) begin
      bit fl, rd, cl;
      fl = ($urandom_range(0, 99) < 45);
      rd = (i < 250) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 80);
      cl = ($urandom_range(0, 99) < 5);
      step(fl, 8'($urandom), rd, cl, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
